// File: rtl/mag_pkg.sv
// Shared types and constants for the time-multiplexed magnitude engine.
package mag_pkg;

   localparam int MAG_W_DEF    = 8;
   localparam int MAG_NREQ_DEF = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SQUARE = 2'd1,
      ROOT   = 2'd2,
      DONE   = 2'd3
   } mag_state_e;

   // Index width for n items, never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/isqrt_iter.sv
// Restoring integer square root, one result bit per enabled cycle, MSB first.
module isqrt_iter
   import mag_pkg::*;
#(
   parameter int W = MAG_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         start,
   input  logic [2*W:0] sum,
   output logic         done,
   output logic [W:0]   root
);

   localparam int BW = $clog2(W + 1);

   logic [BW-1:0]  bit_idx;
   logic           active;
   logic [W:0]     cand;
   logic [2*W+1:0] cand_ext;
   logic [2*W+1:0] cand_sq;

   always_comb begin
      cand     = root | ((W+1)'(1) << bit_idx);
      cand_ext = {{(W+1){1'b0}}, cand};
      cand_sq  = cand_ext * cand_ext;
   end

   // done is asserted during the bit-0 cycle so the caller can leave ROOT on that edge
   assign done = active && (bit_idx == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         root    <= '0;
         bit_idx <= '0;
         active  <= 1'b0;
      end else if (ena) begin
         if (start) begin
            root    <= '0;
            bit_idx <= BW'(W);
            active  <= 1'b1;
         end else if (active) begin
            if ({1'b0, sum} >= cand_sq) root <= cand;
            if (bit_idx == '0) active  <= 1'b0;
            else               bit_idx <= bit_idx - 1'b1;
         end
      end
   end

endmodule

// File: rtl/magnitude_sched.sv
// Round-robin front end sharing one floor(sqrt(x^2+y^2)) engine among NREQ requesters.
module magnitude_sched
   import mag_pkg::*;
#(
   parameter int NREQ = MAG_NREQ_DEF,
   parameter int W    = MAG_W_DEF,
   localparam int IDW = clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_x,
   input  logic [NREQ*W-1:0] req_y,
   output logic [NREQ-1:0]   req_ready,
   output logic              resp_valid,
   output logic [W:0]        resp_mag,
   output logic [IDW-1:0]    resp_id,
   input  logic              resp_ready,
   output logic              busy
);

   mag_state_e     state, state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] id_q;
   logic [W-1:0]   x_q, y_q;
   logic [2*W:0]   sum_q, sum_d;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0] gnt_id;
   logic           gnt_any;
   logic           req_hs;
   logic           iq_done;
   logic [W:0]     root;

   // Search from the RR pointer upward with wrap; the first valid requester wins.
   always_comb begin
      int idx;
      idx     = 0;
      grant   = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
      grant[gnt_id] = gnt_any;
   end

   // rst_n is folded in so req_ready reads 0 while reset is held, like every other output
   assign req_ready = (rst_n && ena && state == IDLE) ? grant : '0;
   assign req_hs    = |(req_ready & req_valid);

   always_comb begin
      sum_d = {{(W+1){1'b0}}, x_q} * {{(W+1){1'b0}}, x_q}
            + {{(W+1){1'b0}}, y_q} * {{(W+1){1'b0}}, y_q};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_hs)     state_nxt = SQUARE;
         SQUARE:                  state_nxt = ROOT;
         ROOT:    if (iq_done)    state_nxt = DONE;
         DONE:    if (resp_ready) state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         id_q  <= '0;
         x_q   <= '0;
         y_q   <= '0;
         sum_q <= '0;
      end else if (ena) begin
         state <= state_nxt;
         if (req_hs) begin
            id_q <= gnt_id;
            x_q  <= req_x[int'(gnt_id)*W +: W];
            y_q  <= req_y[int'(gnt_id)*W +: W];
            ptr  <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
         end
         if (state == SQUARE) sum_q <= sum_d;
      end
   end

   // Root iteration is started on the SQUARE edge, so it runs against sum_q from ROOT onward.
   isqrt_iter #(.W(W)) u_isqrt (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .start (state == SQUARE),
      .sum   (sum_q),
      .done  (iq_done),
      .root  (root)
   );

   assign resp_valid = (state == DONE);
   assign resp_mag   = root;
   assign resp_id    = id_q;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_magnitude_sched.sv
// Directed bench for magnitude_sched: latency, arbitration, backpressure, enable and reset.
module tb_magnitude_sched;

   localparam int NREQ = 2;
   localparam int W    = 8;

   logic            clk;
   logic            rst_n;
   logic            ena;
   logic [NREQ-1:0] req_valid;
   logic [NREQ*W-1:0] req_x;
   logic [NREQ*W-1:0] req_y;
   logic [NREQ-1:0] req_ready;
   logic            resp_valid;
   logic [W:0]      resp_mag;
   logic [0:0]      resp_id;
   logic            resp_ready;
   logic            busy;

   int total = 0;
   int bad   = 0;

   magnitude_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .req_valid  (req_valid),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_mag   (resp_mag),
      .resp_id    (resp_id),
      .resp_ready (resp_ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request, waits (bounded) for its grant, and returns one cycle after the handshake.
   task automatic grant(input int i, input logic [7:0] x, input logic [7:0] y, input string tag);
      int n;
      n = 0;
      req_valid[i]      = 1'b1;
      req_x[i*W +: W]   = x;
      req_y[i*W +: W]   = y;
      #1;
      while (req_ready[i] !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      chk({tag, "_ready"}, req_ready, 32'(1 << i));
      step();
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_resp(input int lat0, input int exp_lat, input int mag, input int id,
                            input string tag);
      int lat;
      lat = lat0;
      while (resp_valid !== 1'b1 && lat < 60) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_mag"}, resp_mag, mag);
      chk({tag, "_id"}, resp_id, id);
   endtask

   task automatic finish_resp(input string tag);
      step();
      chk({tag, "_drop"}, resp_valid, 0);
   endtask

   task automatic run_one(input int i, input logic [7:0] x, input logic [7:0] y, input int mag,
                          input string tag);
      grant(i, x, y, tag);
      wait_resp(1, W + 3, mag, i, tag);
      finish_resp(tag);
   endtask

   task automatic pair(input string tag);
      req_valid[1] = 1'b1;
      req_x[W +: W] = 8'd5;
      req_y[W +: W] = 8'd12;
      grant(0, 8'd6, 8'd8, {tag, "_r0"});
      wait_resp(1, W + 3, 10, 0, {tag, "_r0"});
      step();
      chk({tag, "_regrant"}, req_ready, 2);
      grant(1, 8'd5, 8'd12, {tag, "_r1"});
      wait_resp(1, W + 3, 13, 1, {tag, "_r1"});
      finish_resp({tag, "_r1"});
   endtask

   initial begin
      int lat;
      rst_n      = 1'b0;
      ena        = 1'b1;
      req_valid  = '0;
      req_x      = '0;
      req_y      = '0;
      resp_ready = 1'b1;
      #2;
      chk("rst_valid", resp_valid, 0);
      chk("rst_mag", resp_mag, 0);
      chk("rst_id", resp_id, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // single request: latency, busy window
      grant(0, 8'd3, 8'd4, "t1");
      chk("t1_busy_sq", busy, 1);
      wait_resp(1, 11, 5, 0, "t1");
      chk("t1_busy_done", busy, 1);
      finish_resp("t1");
      chk("t1_busy_idle", busy, 0);

      // requester 1 operand corners
      run_one(1, 8'd255, 8'd255, 360, "t2_max");
      run_one(1, 8'd0, 8'd0, 0, "t2_zero");
      run_one(1, 8'd0, 8'd200, 200, "t2_axis");

      // simultaneous requests, twice to confirm pointer wrap
      pair("t3a");
      pair("t3b");

      // r1 keeps requesting; r0 must still be served next
      grant(1, 8'd9, 8'd12, "t4_r1");
      req_valid[0] = 1'b1;
      req_x[0 +: W] = 8'd8;
      req_y[0 +: W] = 8'd15;
      req_valid[1] = 1'b1;
      req_x[W +: W] = 8'd20;
      req_y[W +: W] = 8'd21;
      wait_resp(1, W + 3, 15, 1, "t4_r1");
      step();
      chk("t4_r0_next", req_ready, 1);
      grant(0, 8'd8, 8'd15, "t4_r0");
      wait_resp(1, W + 3, 17, 0, "t4_r0");
      step();
      grant(1, 8'd20, 8'd21, "t4_r1b");
      wait_resp(1, W + 3, 29, 1, "t4_r1b");
      finish_resp("t4_r1b");

      // consumer backpressure
      resp_ready = 1'b0;
      grant(0, 8'd3, 8'd4, "t5");
      wait_resp(1, W + 3, 5, 0, "t5");
      req_valid[1] = 1'b1;
      req_x[W +: W] = 8'd7;
      req_y[W +: W] = 8'd24;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("t5_hold_valid", resp_valid, 1);
         chk("t5_hold_mag", resp_mag, 5);
         chk("t5_hold_id", resp_id, 0);
         chk("t5_hold_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      step();
      chk("t5_one_hs", resp_valid, 0);
      chk("t5_next_grant", req_ready, 2);
      grant(1, 8'd7, 8'd24, "t5_r1");
      wait_resp(1, W + 3, 25, 1, "t5_r1");
      finish_resp("t5_r1");

      // enable low: no grant in IDLE, then a 5-cycle freeze inside ROOT
      req_valid[0] = 1'b1;
      req_x[0 +: W] = 8'd3;
      req_y[0 +: W] = 8'd4;
      ena = 1'b0;
      #1;
      chk("t6_idle_ready", req_ready, 0);
      step();
      chk("t6_idle_busy", busy, 0);
      ena = 1'b1;
      grant(0, 8'd3, 8'd4, "t6");
      step();
      step();
      lat = 3;
      req_valid[1] = 1'b1;
      req_x[W +: W] = 8'd0;
      req_y[W +: W] = 8'd0;
      ena = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t6_frz_ready", req_ready, 0);
         step();
         lat++;
      end
      ena = 1'b1;
      wait_resp(lat, 16, 5, 0, "t6");
      finish_resp("t6");
      grant(1, 8'd0, 8'd0, "t6_r1");
      wait_resp(1, W + 3, 0, 1, "t6_r1");
      finish_resp("t6_r1");

      // asynchronous reset during ROOT
      grant(0, 8'd255, 8'd255, "t7");
      step();
      step();
      step();
      req_valid[1] = 1'b1;
      req_x[W +: W] = 8'd5;
      req_y[W +: W] = 8'd12;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_valid", resp_valid, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_ready", req_ready, 0);
      chk("t7_rst_mag", resp_mag, 0);
      chk("t7_rst_id", resp_id, 0);
      step();
      req_valid[1] = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         step();
         chk("t7_no_stale", resp_valid, 0);
      end
      run_one(1, 8'd5, 8'd12, 13, "t7_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
